// File: rtl/uart_rx_if.sv
// WFIFO-side bundle of the UART receiver: write strobe/data toward the
// write FIFO, its full flag, and the receive status/clear signals.
// master: the receiver (drives write + status); slave: FIFO/host side.
interface uart_rx_if;
  logic       wfifo_full;     // WFIFO full flag
  logic       wfifo_wr_en;    // one-clock write strobe
  logic [7:0] wfifo_wr_data;  // received byte, qualified by wfifo_wr_en
  logic       frame_err;      // one-clock pulse: stop bit sampled low
  logic       overrun;        // sticky: good byte dropped on full WFIFO
  logic       ovr_clr;        // clears overrun

  modport master (
    input  wfifo_full,
    input  ovr_clr,
    output wfifo_wr_en,
    output wfifo_wr_data,
    output frame_err,
    output overrun
  );

  modport slave (
    output wfifo_full,
    output ovr_clr,
    input  wfifo_wr_en,
    input  wfifo_wr_data,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: deserialises rs232_rx and writes each good byte to WFIFO.
// Latency: write strobe 9*(BAUD_END+1)+BAUD_M+1 clocks after START entry.
// Backpressure: none on the line; a byte arriving while WFIFO is full is
// dropped and flagged on the sticky overrun bit.
// Ports: clk, rst_n (sync, active-low), rs232_rx (async serial in, idles high),
//        wfifo (uart_rx_if.master: wfifo_full/ovr_clr in, wfifo_wr_en,
//        wfifo_wr_data, frame_err, overrun out).
module uart_rx #(
  parameter int BAUD_END = 434,
  parameter int BAUD_M   = BAUD_END / 2 - 1,
  parameter int BIT_NUM  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  uart_rx_if.master  wfifo
);

  localparam int CNT_W = $clog2(BAUD_END + 1);
  localparam int BC_W  = (BIT_NUM > 1) ? $clog2(BIT_NUM) : 1;

  localparam logic [CNT_W-1:0] BAUD_END_C = CNT_W'(BAUD_END);
  localparam logic [CNT_W-1:0] BAUD_M_C   = CNT_W'(BAUD_M);
  localparam logic [BC_W-1:0]  BIT_LAST_C = BC_W'(BIT_NUM - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [BC_W-1:0]  bit_cnt_q;
  logic [7:0]       shift_q;
  logic             rx_s1_q;
  logic             rx_s2_q;
  logic             rx_s3_q;
  logic             wr_en_q;
  logic [7:0]       wr_data_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             overrun_d;

  logic fall_edge;
  logic bit_flag;
  logic samp;
  logic drop_byte;

  // rx_s1 is the metastability catcher; edges are judged on s2/s3 only.
  assign fall_edge = ~rx_s2_q & rx_s3_q;
  assign bit_flag  = (baud_cnt_q == BAUD_END_C);
  assign samp      = (baud_cnt_q == BAUD_M_C);

  // A good stop bit with WFIFO full is the only way a byte is lost.
  assign drop_byte = (state_q == STOP) && samp && rx_s2_q && wfifo.wfifo_full;

  always_comb begin
    overrun_d = overrun_q;
    if (wfifo.ovr_clr) begin
      overrun_d = 1'b0;
    end
    // Set takes priority over a clear in the same cycle.
    if (drop_byte) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_s1_q     <= rs232_rx;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= overrun_d;

      case (state_q)
        IDLE: begin
          baud_cnt_q <= '0;
          if (fall_edge) begin
            state_q <= START;
          end
        end

        START: begin
          if (samp && rx_s2_q) begin
            // Glitch shorter than half a bit: abandon silently.
            state_q    <= IDLE;
            baud_cnt_q <= '0;
          end else if (bit_flag) begin
            state_q    <= DATA;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (samp) begin
            shift_q <= {rx_s2_q, shift_q[7:1]};  // LSB arrives first
          end
          if (bit_flag) begin
            baud_cnt_q <= '0;
            if (bit_cnt_q == BIT_LAST_C) begin
              state_q   <= STOP;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (samp) begin
            // Leave at mid-stop so the rest of the bit is spent in IDLE,
            // where a back-to-back start edge can be caught.
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            if (rx_s2_q) begin
              if (!wfifo.wfifo_full) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= shift_q;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q    <= IDLE;
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
        end
      endcase
    end
  end

  assign wfifo.wfifo_wr_en   = wr_en_q;
  assign wfifo.wfifo_wr_data = wr_data_q;
  assign wfifo.frame_err     = frame_err_q;
  assign wfifo.overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int BIT_CLKS = 435;

  typedef struct {
    bit         is_fe;
    logic [7:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rs232_rx;
  int   cyc = 0;

  int   total = 0;
  int   bad   = 0;
  int   ev_cnt = 0;
  int   ev_mark;
  exp_t exp_q[$];
  int   wr_cyc[$];

  uart_rx_if u_if ();

  uart_rx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs232_rx (rs232_rx),
    .wfifo    (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_wr(input logic [7:0] b);
    exp_t e;
    e.is_fe = 1'b0;
    e.dat   = b;
    exp_q.push_back(e);
  endtask

  task automatic push_fe();
    exp_t e;
    e.is_fe = 1'b1;
    e.dat   = 8'h00;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at a negedge with the line at 'stop'.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rs232_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rs232_rx = stop;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    logic [7:0] partial;
    rst_n          = 1'b0;
    rs232_rx       = 1'b1;
    u_if.wfifo_full = 1'b0;
    u_if.ovr_clr   = 1'b0;

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    fork
      forever begin
        @(negedge clk);
        if (u_if.wfifo_wr_en === 1'b1) begin
          ev_cnt++;
          wr_cyc.push_back(cyc);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_wr_en: got write data=%02h required no event", u_if.wfifo_wr_data);
          end else begin
            e = exp_q.pop_front();
            if (e.is_fe || u_if.wfifo_wr_data !== e.dat) begin
              bad++;
              $display("FAIL wr_byte: got write data=%02h required %s %02h",
                       u_if.wfifo_wr_data, e.is_fe ? "frame_err" : "write", e.dat);
            end
          end
        end
        if (u_if.frame_err === 1'b1) begin
          ev_cnt++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_frame_err: got frame_err required no event");
          end else begin
            e = exp_q.pop_front();
            if (!e.is_fe) begin
              bad++;
              $display("FAIL frame_err_event: got frame_err required write %02h", e.dat);
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(u_if.wfifo_wr_en), 32'd0);
    check("rst_wr_data", 32'(u_if.wfifo_wr_data), 32'd0);
    check("rst_frame_err", 32'(u_if.frame_err), 32'd0);
    check("rst_overrun", 32'(u_if.overrun), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single byte 0xA5
    push_wr(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check("a5_pending", 32'(exp_q.size()), 32'd0);
    check("a5_overrun", 32'(u_if.overrun), 32'd0);

    // Back-to-back 0x00 then 0xFF, no idle gap
    wr_cyc.delete();
    push_wr(8'h00);
    push_wr(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_count", 32'(wr_cyc.size()), 32'd2);
    if (wr_cyc.size() == 2)
      check("b2b_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4350);

    // False start: 100 clocks low
    ev_mark = ev_cnt;
    rs232_rx = 1'b0;
    repeat (100) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (1000) @(negedge clk);
    check("false_start_events", 32'(ev_cnt), 32'(ev_mark));

    // Framing error on 0x3C, then break for 5000 clocks
    ev_mark = ev_cnt;
    push_fe();
    send_frame(8'h3C, 1'b0);
    repeat (5000) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (1000) @(negedge clk);
    check("break_events", 32'(ev_cnt), 32'(ev_mark + 1));
    check("break_pending", 32'(exp_q.size()), 32'd0);

    // Overrun on full WFIFO, clear, then normal write
    ev_mark = ev_cnt;
    u_if.wfifo_full = 1'b1;
    send_frame(8'h5A, 1'b1);
    u_if.wfifo_full = 1'b0;
    check("ovr_set", 32'(u_if.overrun), 32'd1);
    check("ovr_no_write", 32'(ev_cnt), 32'(ev_mark));
    repeat (50) @(negedge clk);
    check("ovr_held", 32'(u_if.overrun), 32'd1);
    u_if.ovr_clr = 1'b1;
    @(negedge clk);
    u_if.ovr_clr = 1'b0;
    check("ovr_cleared", 32'(u_if.overrun), 32'd0);
    push_wr(8'h11);
    send_frame(8'h11, 1'b1);
    repeat (20) @(negedge clk);
    check("after_ovr_pending", 32'(exp_q.size()), 32'd0);
    check("after_ovr_overrun", 32'(u_if.overrun), 32'd0);

    // Reset during data bit 4 of 0x77
    ev_mark = ev_cnt;
    partial = 8'h77;
    rs232_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rs232_rx = partial[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rs232_rx = partial[4];
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rs232_rx = 1'b1;
    repeat (3000) @(negedge clk);
    check("rst_mid_events", 32'(ev_cnt), 32'(ev_mark));
    check("rst_mid_frame_err", 32'(u_if.frame_err), 32'd0);
    push_wr(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
